// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor: WIDTH bits split into STAGES chunks,
// one chunk per cycle, carries registered between chunks, one new operation per cycle.
module pipelined_adder #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CHUNK = WIDTH / STAGES;

  // Per-stage registers: stage k owns chunk k; part_q carries the already-summed low chunks
  logic             valid_q [STAGES];
  logic             valid_d [STAGES];
  logic             carry_q [STAGES];
  logic             carry_d [STAGES];
  logic [WIDTH-1:0] part_q  [STAGES];
  logic [WIDTH-1:0] part_d  [STAGES];
  logic [WIDTH-1:0] opa_q   [STAGES];
  logic [WIDTH-1:0] opa_d   [STAGES];
  logic [WIDTH-1:0] opb_q   [STAGES];
  logic [WIDTH-1:0] opb_d   [STAGES];
  logic             ovf_q;
  logic             ovf_d;

  // Stage inputs as seen by the adder of each stage
  logic             stg_v    [STAGES];
  logic             stg_c    [STAGES];
  logic [WIDTH-1:0] stg_a    [STAGES];
  logic [WIDTH-1:0] stg_b    [STAGES];
  logic [WIDTH-1:0] stg_part [STAGES];
  logic [CHUNK:0]   chunk_sum [STAGES];
  logic [WIDTH-1:0] b_eff;

  always_comb begin
    b_eff       = sub ? ~b : b;
    stg_v[0]    = in_valid;
    stg_c[0]    = sub | cin;
    stg_a[0]    = a;
    stg_b[0]    = b_eff;
    stg_part[0] = '0;
    for (int k = 1; k < int'(STAGES); k++) begin
      stg_v[k]    = valid_q[k-1];
      stg_c[k]    = carry_q[k-1];
      stg_a[k]    = opa_q[k-1];
      stg_b[k]    = opb_q[k-1];
      stg_part[k] = part_q[k-1];
    end

    for (int k = 0; k < int'(STAGES); k++) begin
      chunk_sum[k] = (CHUNK+1)'(stg_a[k][k*CHUNK +: CHUNK])
                   + (CHUNK+1)'(stg_b[k][k*CHUNK +: CHUNK])
                   + (CHUNK+1)'(stg_c[k]);
      valid_d[k] = stg_v[k];
      carry_d[k] = carry_q[k];
      part_d[k]  = part_q[k];
      opa_d[k]   = opa_q[k];
      opb_d[k]   = opb_q[k];
      if (stg_v[k]) begin
        carry_d[k]                   = chunk_sum[k][CHUNK];
        part_d[k]                    = stg_part[k];
        part_d[k][k*CHUNK +: CHUNK]  = chunk_sum[k][CHUNK-1:0];
        opa_d[k]                     = stg_a[k];
        opb_d[k]                     = stg_b[k];
      end
    end

    // Carry into the MSB is recovered as a^b^s at that bit
    ovf_d = ovf_q;
    if (stg_v[STAGES-1]) begin
      ovf_d = stg_a[STAGES-1][WIDTH-1] ^ stg_b[STAGES-1][WIDTH-1]
            ^ chunk_sum[STAGES-1][CHUNK-1] ^ chunk_sum[STAGES-1][CHUNK];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        valid_q[k] <= 1'b0;
        carry_q[k] <= 1'b0;
        part_q[k]  <= '0;
        opa_q[k]   <= '0;
        opb_q[k]   <= '0;
      end
      ovf_q <= 1'b0;
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        valid_q[k] <= valid_d[k];
        carry_q[k] <= carry_d[k];
        part_q[k]  <= part_d[k];
        opa_q[k]   <= opa_d[k];
        opb_q[k]   <= opb_d[k];
      end
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign sum       = part_q[STAGES-1];
  assign cout      = carry_q[STAGES-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench: four adder instances (STAGES 1,2,4,16) share stimulus and are
// checked every cycle against a whole-word arithmetic model; directed vectors use the 4-stage one.
module tb_pipelined_adder;

  localparam int unsigned W = 16;
  localparam int ND = 4;

  typedef struct {
    logic         v;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
  } rec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] e_sum;
    logic         e_cout;
    logic         e_ovf;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;

  logic         ov [ND];
  logic [W-1:0] sm [ND];
  logic         co [ND];
  logic         of [ND];

  int n_checks = 0;
  int n_fail   = 0;

  rec_t hist[$];
  res_t held [ND];

  always #5 clk = ~clk;

  function automatic int stg(input int d);
    return (d == 0) ? 1 : (d == 1) ? 2 : (d == 2) ? 4 : 16;
  endfunction

  for (genvar g = 0; g < ND; g++) begin : g_dut
    pipelined_adder #(
      .WIDTH (W),
      .STAGES((g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 16)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .sub      (sub),
      .out_valid(ov[g]),
      .sum      (sm[g]),
      .cout     (co[g]),
      .ovf      (of[g])
    );
  end

  // Whole-word reference: subtract is a + (two's complement of b), overflow by sign rule
  function automatic res_t model(input rec_t r);
    res_t         o;
    logic [W:0]   full;
    logic [W-1:0] be;
    be     = r.sub ? ~r.b : r.b;
    full   = {1'b0, r.a} + {1'b0, be} + (W+1)'(r.sub ? 1'b1 : r.cin);
    o.sum  = full[W-1:0];
    o.cout = full[W];
    o.ovf  = (r.a[W-1] == be[W-1]) && (full[W-1] != r.a[W-1]);
    return o;
  endfunction

  task automatic cmp(input string name, input int d, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s stages=%0d t=%0t got=%h expected=%h", name, stg(d), $time, got, exp);
    end
  endtask

  task automatic check_model();
    for (int d = 0; d < ND; d++) begin
      int   idx;
      logic ev;
      idx = hist.size() - stg(d);
      ev  = 1'b0;
      if (idx >= 0 && hist[idx].v) begin
        held[d] = model(hist[idx]);
        ev      = 1'b1;
      end
      cmp("out_valid", d, 32'(ov[d]), 32'(ev));
      cmp("sum",       d, 32'(sm[d]), 32'(held[d].sum));
      cmp("cout",      d, 32'(co[d]), 32'(held[d].cout));
      cmp("ovf",       d, 32'(of[d]), 32'(held[d].ovf));
    end
  endtask

  task automatic step(input logic v, input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input logic ic, input logic is);
    rec_t r;
    @(negedge clk);
    in_valid = v; a = ia; b = ib; cin = ic; sub = is;
    @(posedge clk);
    r.v = v; r.a = ia; r.b = ib; r.cin = ic; r.sub = is;
    hist.push_back(r);
    #1;
    check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // Reset asserted mid-cycle; optionally with a valid operand presented that must be dropped
  task automatic pulse_reset(input logic v);
    @(negedge clk);
    rst = 1'b1; in_valid = v; a = 16'h1111; b = 16'h2222;
    hist.delete();
    for (int d = 0; d < ND; d++) held[d] = '{sum: '0, cout: 1'b0, ovf: 1'b0};
    #1;
    check_model();
    @(posedge clk);
    #1;
    check_model();
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
  endtask

  vec_t vecs [8];

  initial begin
    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0};
    vecs[5] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
    vecs[6] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

    pulse_reset(1'b0);
    idle(2);

    // Directed vectors on the 4-stage instance: result after 3 more edges, valid exactly one cycle
    for (int i = 0; i < 8; i++) begin
      step(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      idle(3);
      cmp("vec_valid", 2, 32'(ov[2]), 32'd1);
      cmp("vec_sum",   2, 32'(sm[2]), 32'(vecs[i].e_sum));
      cmp("vec_cout",  2, 32'(co[2]), 32'(vecs[i].e_cout));
      cmp("vec_ovf",   2, 32'(of[2]), 32'(vecs[i].e_ovf));
      idle(1);
      cmp("vec_pulse", 2, 32'(ov[2]), 32'd0);
    end
    idle(16);

    // Streaming: four mixed ops, a bubble, two more
    step(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0);
    step(1'b1, 16'h0100, 16'h0200, 1'b1, 1'b1);
    step(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    step(1'b1, 16'h8000, 16'h7FFF, 1'b0, 1'b1);
    step(1'b0, 16'hAAAA, 16'h5555, 1'b1, 1'b1);
    step(1'b1, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
    step(1'b1, 16'h0000, 16'h0001, 1'b0, 1'b1);
    idle(16);

    // Hold: outputs keep the last result while inputs toggle with in_valid low
    step(1'b1, 16'h4000, 16'h4000, 1'b0, 1'b0);
    idle(16);
    idle(10);

    // Reset mid-flight: two accepted, third presented as reset asserts
    step(1'b1, 16'h0F0F, 16'h0101, 1'b0, 1'b0);
    step(1'b1, 16'hFFF0, 16'h0020, 1'b0, 1'b1);
    pulse_reset(1'b1);
    idle(3);
    step(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b0);
    idle(4);
    cmp("post_reset_sum", 2, 32'(sm[2]), 32'h0100);
    idle(16);

    // Random operands and valid patterns
    for (int i = 0; i < 1000; i++) begin
      step(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
           1'($urandom), 1'($urandom));
    end
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined ripple-carry adder/subtractor: the successor to the team's fixed 4-bit ripple adder. It splits a WIDTH-bit add into STAGES equal chunks and registers the carry between chunks, so the long carry chain spreads over several cycles and a new operand pair can be accepted every cycle. It adds a subtract mode, signed overflow detection and a valid pipeline, and sits in datapaths that need wide adds at high clock rates.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages, 1..WIDTH. Each stage handles CHUNK = WIDTH/STAGES bits.
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands valid this cycle; accepted unconditionally (no backpressure).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for add mode; ignored when sub=1.
- sub  input  1  0: a+b+cin; 1: a-b (computed as a + ~b + 1).
- out_valid  output  1  result valid this cycle.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB. In sub mode, 1 means no borrow (a >= b unsigned).
- ovf  output  1  two's-complement signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- Input stage: on accept, b is replaced by ~b when sub=1, and the effective carry becomes sub ? 1 : cin.
- Stage k (0..STAGES-1) adds bits [k*CHUNK +: CHUNK] of A and the effective B, plus the carry registered by stage k-1 (stage 0 uses the effective carry). It registers its CHUNK-bit partial sum and its carry-out.
- Skew registers delay the upper operand chunks so that chunk k reaches stage k exactly k cycles after acceptance.
- Deskew registers delay the lower partial sums so that all chunks of one operation appear on sum in the same cycle.
- Stage STAGES-1 also produces cout and ovf. ovf is computed from the carry into and out of bit WIDTH-1 within the final chunk.
- One valid bit per stage travels with the data. A stage's data registers load only when its incoming valid is 1; otherwise they hold.
- sum, cout and ovf hold the last valid result while out_valid=0.
- Operations never interact: per-operation carries travel in their own stage registers. Back-to-back operations with mixed add/sub are legal.
- STAGES=1 degenerates to a single registered full-width ripple adder.

## Timing
- Reset (asynchronous assert, synchronous release on the next edge): all valid bits 0, so out_valid=0. sum, all partial sums, cout, ovf, carry and skew registers are 0.
- Latency: operands accepted at rising edge t (in_valid=1) produce out_valid=1 with their result after edge t+STAGES-1. That is a STAGES-cycle register path counting the accepting edge; for STAGES=1 the result is visible right after the accepting edge.
- Throughput: one operation per cycle. Results leave in acceptance order, with bubbles preserved exactly. in_valid=0 at edge t gives out_valid=0 in the corresponding output cycle.
- out_valid is high for exactly one cycle per accepted operation.
- Reset mid-operation discards all in-flight operations: out_valid stays 0 until newly accepted data completes the full latency.
- The rst deassertion edge accepts nothing. The first acceptance is on the following edge.
- a, b, cin and sub are sampled only at the accepting edge; changes in other cycles have no effect.

## Test plan
- WIDTH=16, STAGES=4, add: a=0xFFFF, b=0x0001, cin=0 -> after 4-cycle latency, sum=0x0000, cout=1, ovf=0, out_valid high for exactly 1 cycle.
- Signed overflow: add 0x7FFF+0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Sub 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- Sub with borrow: 0x0005-0x0007 with cin=1 (ignored) -> sum=0xFFFE, cout=0, ovf=0. Add 0x1234+0x0FFF with cin=1 -> sum=0x2234, cout=0.
- Streaming: 4 consecutive cycles of mixed add/sub, then a bubble, then 2 more -> results emerge in order with one out_valid=0 gap, each matching a reference model. Repeat for 1000 random operand and valid patterns at STAGES=1, 2, 4 and 16.
- Reset mid-flight: accept 3 operations, assert rst for 1 cycle after the 2nd edge -> out_valid stays 0 for all 3 and all outputs read 0. A new operation after release completes with correct latency and result.
- Hold behaviour: after one valid result, hold in_valid=0 for 10 cycles while toggling a/b/sub -> sum, cout and ovf stay unchanged and out_valid stays 0.
